// File: rtl/mem_data_ram_sized.sv
// mem_data_ram_sized
//   Byte-addressable, big-endian data RAM for the RV32E load/store path.
//   Supports byte / half-word / word accesses with sign or zero extension on
//   loads, rejects misaligned, illegal-size and out-of-range requests, and
//   zero-fills the whole array after every reset before taking requests.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req_valid    request present
//   req_ready    request can be accepted this cycle (high only in READY)
//   req_write    1 = store, 0 = load
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned load zero-extends when 1, sign-extends when 0
//   addr         byte address (full 32 bits are range-checked)
//   wdata        store data, right-justified
//   rsp_valid    one-cycle response pulse, the cycle after accept
//   rdata        load result; 0 for stores, errors and idle cycles
//   rsp_err      request rejected; qualified by rsp_valid
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready depends only on the FSM state, never on
// req_valid. Every accepted request yields exactly one rsp_valid pulse in the
// next cycle; there is no response back-pressure.

module mem_data_ram_sized #(
    parameter int DEPTH_BYTES = 512,
    parameter int CLR_WORDS   = DEPTH_BYTES / 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    // The clear counter indexes words, so it is two bits narrower than a byte index.
    localparam int CW = AW - 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] clr_cnt;
    logic [7:0]    mem [DEPTH_BYTES];

    logic          accept;
    logic [32:0]   nbytes;
    logic [32:0]   last_addr;
    logic          size_err;
    logic          align_err;
    logic          range_err;
    logic          err;
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic [7:0]    b0, b1, b2, b3;
    logic          sx;
    logic [31:0]   load_val;

    assign req_ready = (state == ST_READY);
    assign accept    = req_valid & req_ready;

    always_comb begin
        nbytes    = 33'd1;
        size_err  = 1'b0;
        align_err = 1'b0;
        case (req_size)
            2'b00: nbytes = 33'd1;
            2'b01: begin
                nbytes    = 33'd2;
                align_err = addr[0];
            end
            2'b10: begin
                nbytes    = 33'd4;
                align_err = (addr[1:0] != 2'b00);
            end
            default: size_err = 1'b1;
        endcase
        // 33-bit sum so an address near 0xFFFFFFFF cannot wrap back into range.
        last_addr = {1'b0, addr} + nbytes - 33'd1;
        range_err = (last_addr >= 33'(DEPTH_BYTES));
        err       = size_err | align_err | range_err;
    end

    // Neighbour indices wrap inside the array; they are only used when the
    // range check has passed, so the wrap never reaches a real access.
    assign idx0 = addr[AW-1:0];
    assign idx1 = idx0 + AW'(1);
    assign idx2 = idx0 + AW'(2);
    assign idx3 = idx0 + AW'(3);

    assign b0 = mem[idx0];
    assign b1 = mem[idx1];
    assign b2 = mem[idx2];
    assign b3 = mem[idx3];

    assign sx = ~req_unsigned;

    // Big-endian: the byte at the lowest address is the most significant.
    always_comb begin
        load_val = '0;
        case (req_size)
            2'b00:   load_val = {{24{sx & b0[7]}}, b0};
            2'b01:   load_val = {{16{sx & b0[7]}}, b0, b1};
            2'b10:   load_val = {b0, b1, b2, b3};
            default: load_val = '0;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
            rdata     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & err;
            rdata     <= (accept && !err && !req_write) ? load_val : '0;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + CW'(1);
                if (clr_cnt == CW'(CLR_WORDS - 1)) begin
                    state <= ST_READY;
                end
            end
        end
    end

    // Storage. The reset edge itself leaves the array untouched; clearing
    // starts on the first edge after reset is released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[{clr_cnt, 2'b00}] <= 8'h00;
                mem[{clr_cnt, 2'b01}] <= 8'h00;
                mem[{clr_cnt, 2'b10}] <= 8'h00;
                mem[{clr_cnt, 2'b11}] <= 8'h00;
            end else if (accept && req_write && !err) begin
                case (req_size)
                    2'b00: mem[idx0] <= wdata[7:0];
                    2'b01: begin
                        mem[idx0] <= wdata[15:8];
                        mem[idx1] <= wdata[7:0];
                    end
                    2'b10: begin
                        mem[idx0] <= wdata[31:24];
                        mem[idx1] <= wdata[23:16];
                        mem[idx2] <= wdata[15:8];
                        mem[idx3] <= wdata[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_data_ram_sized.sv
module tb_mem_data_ram_sized;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Each entry is {expected rsp_err, expected rdata}.
    logic [32:0] exp_q[$];

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    mem_data_ram_sized #(.DEPTH_BYTES(512)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .rsp_valid    (rsp_valid),
        .rdata        (rdata),
        .rsp_err      (rsp_err)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        addr         = a;
        wdata        = d;
    endtask

    // Scoreboard check of the response that follows an accept edge.
    task automatic check_rsp(input string tag);
        logic [32:0] e;
        chk({tag, ".rsp_valid"}, {32'd0, rsp_valid}, 33'd1);
        if (exp_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 33'd1, 33'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".rdata"}, {1'b0, rdata}, {1'b0, e[31:0]});
            chk({tag, ".rsp_err"}, {32'd0, rsp_err}, {32'd0, e[32]});
        end
    endtask

    // Drive one request, push its expectation, clock it in, check the response.
    task automatic issue(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_data, input logic exp_err);
        drive(wr, sz, uns, a, d);
        exp_q.push_back({exp_err, exp_data});
        tick();
        req_valid = 1'b0;
        check_rsp(tag);
    endtask

    task automatic idle_check(input string tag);
        req_valid = 1'b0;
        tick();
        chk({tag, ".rsp_valid"}, {32'd0, rsp_valid}, 33'd0);
        chk({tag, ".rdata"}, {1'b0, rdata}, 33'd0);
        chk({tag, ".rsp_err"}, {32'd0, rsp_err}, 33'd0);
    endtask

    // Expects the current cycle to be the first after a reset edge; checks
    // req_ready stays low for exactly 128 cycles while req_valid is held,
    // and ends in the first READY cycle with req_valid dropped.
    task automatic clear_window(input string tag);
        drive(1'b1, SZ_W, 1'b0, 32'h0000_01FC, 32'hFFFF_FFFF);
        for (int i = 0; i < 128; i++) begin
            chk({tag, ".ready_low"}, {32'd0, req_ready}, 33'd0);
            chk({tag, ".no_rsp"}, {32'd0, rsp_valid}, 33'd0);
            tick();
        end
        chk({tag, ".ready_high"}, {32'd0, req_ready}, 33'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        // Reset, with a store held on the bus throughout the clear.
        rst = 1'b1;
        drive(1'b1, SZ_W, 1'b0, 32'h0000_01FC, 32'hFFFF_FFFF);
        tick();
        rst = 1'b0;
        chk("reset.ready", {32'd0, req_ready}, 33'd0);
        chk("reset.rsp_valid", {32'd0, rsp_valid}, 33'd0);
        chk("reset.rdata", {1'b0, rdata}, 33'd0);
        chk("reset.rsp_err", {32'd0, rsp_err}, 33'd0);
        clear_window("clear1");

        issue("ld_w_1fc", 1'b0, SZ_W, 1'b0, 32'h0000_01FC, 32'h0, 32'h0000_0000, 1'b0);

        // Big-endian word store and narrow loads.
        issue("st_w_10", 1'b1, SZ_W, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue("ld_b_10s", 1'b0, SZ_B, 1'b0, 32'h0000_0010, 32'h0, 32'hFFFF_FFDE, 1'b0);
        issue("ld_b_13u", 1'b0, SZ_B, 1'b1, 32'h0000_0013, 32'h0, 32'h0000_00EF, 1'b0);
        issue("ld_h_12s", 1'b0, SZ_H, 1'b0, 32'h0000_0012, 32'h0, 32'hFFFF_BEEF, 1'b0);
        issue("ld_h_10u", 1'b0, SZ_H, 1'b1, 32'h0000_0010, 32'h0, 32'h0000_DEAD, 1'b0);

        // Byte store only touches one byte; upper wdata bits are ignored.
        issue("st_b_11", 1'b1, SZ_B, 1'b0, 32'h0000_0011, 32'hFFFF_FF7A, 32'h0, 1'b0);
        issue("ld_w_10", 1'b0, SZ_W, 1'b0, 32'h0000_0010, 32'h0, 32'hDE7A_BEEF, 1'b0);
        issue("ld_b_10u", 1'b0, SZ_B, 1'b1, 32'h0000_0010, 32'h0, 32'h0000_00DE, 1'b0);
        issue("ld_b_12u", 1'b0, SZ_B, 1'b1, 32'h0000_0012, 32'h0, 32'h0000_00BE, 1'b0);
        issue("ld_b_13s", 1'b0, SZ_B, 1'b0, 32'h0000_0013, 32'h0, 32'hFFFF_FFEF, 1'b0);

        // Half store, then rejected requests must leave memory alone.
        issue("st_w_20", 1'b1, SZ_W, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0, 1'b0);
        issue("st_h_24", 1'b1, SZ_H, 1'b0, 32'h0000_0024, 32'hFFFF_8001, 32'h0, 1'b0);
        issue("ld_h_24s", 1'b0, SZ_H, 1'b0, 32'h0000_0024, 32'h0, 32'hFFFF_8001, 1'b0);
        issue("err_st_h_21", 1'b1, SZ_H, 1'b0, 32'h0000_0021, 32'hAAAA_AAAA, 32'h0, 1'b1);
        issue("err_st_w_22", 1'b1, SZ_W, 1'b0, 32'h0000_0022, 32'hAAAA_AAAA, 32'h0, 1'b1);
        issue("err_st_sz11", 1'b1, SZ_X, 1'b0, 32'h0000_0020, 32'hAAAA_AAAA, 32'h0, 1'b1);
        issue("err_ld_sz11", 1'b0, SZ_X, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 1'b1);
        issue("err_ld_h_21", 1'b0, SZ_H, 1'b0, 32'h0000_0021, 32'h0, 32'h0, 1'b1);
        issue("err_st_w_1fe", 1'b1, SZ_W, 1'b0, 32'h0000_01FE, 32'hAAAA_AAAA, 32'h0, 1'b1);
        issue("ld_w_20", 1'b0, SZ_W, 1'b0, 32'h0000_0020, 32'h0, 32'h1122_3344, 1'b0);

        // Range edges.
        issue("err_ld_w_200", 1'b0, SZ_W, 1'b0, 32'h0000_0200, 32'h0, 32'h0, 1'b1);
        issue("err_ld_b_ffff", 1'b0, SZ_B, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
        issue("err_ld_h_1ff", 1'b0, SZ_H, 1'b0, 32'h0000_01FF, 32'h0, 32'h0, 1'b1);
        issue("err_ld_w_210", 1'b0, SZ_W, 1'b0, 32'h0000_0210, 32'h0, 32'h0, 1'b1);
        issue("st_b_1ff", 1'b1, SZ_B, 1'b0, 32'h0000_01FF, 32'h0000_0080, 32'h0, 1'b0);
        issue("ld_b_1ffs", 1'b0, SZ_B, 1'b0, 32'h0000_01FF, 32'h0, 32'hFFFF_FF80, 1'b0);
        issue("ld_h_1fes", 1'b0, SZ_H, 1'b0, 32'h0000_01FE, 32'h0, 32'h0000_0080, 1'b0);
        issue("ld_w_1fc2", 1'b0, SZ_W, 1'b0, 32'h0000_01FC, 32'h0, 32'h0000_0080, 1'b0);

        idle_check("idle1");
        idle_check("idle2");

        // Back-to-back store then load of the same word.
        issue("b2b_st_40", 1'b1, SZ_W, 1'b0, 32'h0000_0040, 32'h0102_0304, 32'h0, 1'b0);
        issue("b2b_ld_40", 1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0, 32'h0102_0304, 1'b0);

        // Reset on the edge where a load would be accepted: no response follows.
        rst = 1'b1;
        drive(1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0);
        tick();
        rst = 1'b0;
        chk("rst_drop.rsp_valid", {32'd0, rsp_valid}, 33'd0);
        chk("rst_drop.rdata", {1'b0, rdata}, 33'd0);
        chk("rst_drop.ready", {32'd0, req_ready}, 33'd0);

        // Reset partway through the clear restarts it from word 0.
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_window("clear2");

        issue("ld_w_40_clr", 1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0000, 1'b0);
        issue("ld_w_10_clr", 1'b0, SZ_W, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0);
        issue("ld_b_1ff_clr", 1'b0, SZ_B, 1'b1, 32'h0000_01FF, 32'h0, 32'h0000_0000, 1'b0);
        idle_check("idle3");

        chk("queue_drained", 33'(exp_q.size()), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
